// File: rtl/tag_nios_system_pio_pkg.sv
// ---------------------------------------------------------------------------
// tag_nios_system_pio_pkg
// Shared constants and helpers for the debounced PIO slave:
//   - Avalon-MM word offsets of the register map
//   - EDGE_TYPE encodings
//   - edge_events : edge detection on the debounced value
//   - w1c_update  : write-1-to-clear update where a new event wins
// ---------------------------------------------------------------------------
package tag_nios_system_pio_pkg;

    // Register map word offsets
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD     = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    // EDGE_TYPE encodings
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Bits of cur that changed from prev in the direction selected by edge_type.
    // Unknown encodings behave as "any edge".
    function automatic logic [31:0] edge_events(input logic [31:0] cur,
                                                input logic [31:0] prev,
                                                input int          edge_type);
        logic [31:0] ev;
        case (edge_type)
            EDGE_RISING:  ev = cur & ~prev;
            EDGE_FALLING: ev = ~cur & prev;
            EDGE_ANY:     ev = cur ^ prev;
            default:      ev = cur ^ prev;
        endcase
        return ev;
    endfunction

    // Capture register update: optional clear of the bits set in clr, then
    // OR in new events so a simultaneous event keeps its bit set.
    function automatic logic [31:0] w1c_update(input logic [31:0] cap,
                                               input logic [31:0] clr,
                                               input logic [31:0] set,
                                               input logic        do_clr);
        logic [31:0] nxt;
        if (do_clr) begin
            nxt = cap & ~clr;
        end else begin
            nxt = cap;
        end
        return nxt | set;
    endfunction

endpackage

// File: rtl/tag_nios_system_debounce_bit.sv
// ---------------------------------------------------------------------------
// tag_nios_system_debounce_bit
// One input bit: 2-flop synchronizer followed by a mismatch-counting
// debouncer. stable follows the synchronized input only after it has
// differed from stable for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   din    - asynchronous raw input
//   stable - debounced, registered value
// ---------------------------------------------------------------------------
module tag_nios_system_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: synchronizer shift and mismatch counter. The counter stops
    // at CNT_LAST, where the change is accepted, so it never wraps.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = CNT_ZERO;
        if (sync2_q == stable_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= CNT_ZERO;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/tag_nios_system_debounced_pio.sv
// ---------------------------------------------------------------------------
// tag_nios_system_debounced_pio
// Avalon-MM PIO input slave with per-bit debouncing, edge capture and a
// level interrupt.
// Register map (word offsets):
//   0 data      - debounced inputs, read-only
//   1 irq_mask  - R/W, WIDTH bits
//   2 reserved  - reads 0, writes ignored
//   3 edge_cap  - captured edges, write 1 to clear
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   chipselect, address - slave select and word offset
//   write, writedata    - write strobe (qualified by chipselect) and data
//   in_port             - asynchronous external inputs
//   readdata            - registered read data, 1-cycle latency
//   irq                 - |(edge_cap & irq_mask), combinational
// ---------------------------------------------------------------------------
import tag_nios_system_pio_pkg::*;

module tag_nios_system_debounced_pio #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] event_s;
    logic             wr_en_s;
    logic [WIDTH-1:0] stable_prev_q, stable_prev_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [31:0]      readdata_q, readdata_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            tag_nios_system_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .din   (in_port[gi]),
                .stable(stable_s[gi])
            );
        end
    endgenerate

    // Next-state for the register file, edge detection and read mux.
    // Edge events compare stable with its one-cycle-old copy, so a capture
    // bit sets on the edge after stable changes.
    always_comb begin
        wr_en_s        = chipselect & write;
        stable_prev_d  = stable_s;
        event_s        = WIDTH'(edge_events(32'(stable_s), 32'(stable_prev_q), EDGE_TYPE));
        edge_capture_d = WIDTH'(w1c_update(32'(edge_capture_q), writedata, 32'(event_s),
                                           wr_en_s && (address == ADDR_EDGE_CAP)));
        if (wr_en_s && (address == ADDR_IRQ_MASK)) begin
            irq_mask_d = WIDTH'(writedata);
        end else begin
            irq_mask_d = irq_mask_q;
        end
        case (address)
            ADDR_DATA:     readdata_d = 32'(stable_s);
            ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
            ADDR_RSVD:     readdata_d = 32'd0;
            ADDR_EDGE_CAP: readdata_d = 32'(edge_capture_q);
            default:       readdata_d = 32'd0;
        endcase
    end

    // Register file and read data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_prev_q  <= {WIDTH{1'b0}};
            irq_mask_q     <= {WIDTH{1'b0}};
            edge_capture_q <= {WIDTH{1'b0}};
            readdata_q     <= 32'd0;
        end else begin
            stable_prev_q  <= stable_prev_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_tag_nios_system_debounced_pio.sv
module tb_tag_nios_system_debounced_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [9:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    tag_nios_system_debounced_pio #(
        .WIDTH          (10),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .chipselect(chipselect),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic cs, input logic wr, input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs;
        write      = wr;
        address    = a;
        writedata  = wd;
    endtask

    initial begin
        // register-map vectors; inputs stay 0 so data and edge_cap remain 0
        vecs[0]  = '{1'b1, 1'b1, 2'd1, 32'hFFFF_F2A5, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0000, 32'h0000_02A5, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_02A5, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'd1, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 32'h0000_0001, 1'b0};

        reset   = 1'b1;
        in_port = 10'h000;
        bus(1'b0, 1'b0, 2'd0, 32'h0);
        step();
        step();
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        bus(1'b1, 1'b0, 2'd0, 32'h0);
        step();
        chk("idle_data", readdata, 32'h0);
        chk("idle_irq", 32'(irq), 32'h0);

        // register map table
        for (int i = 0; i < 13; i++) begin
            bus(vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            step();
            chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // 3-cycle glitch on bit 0 must be rejected
        bus(1'b1, 1'b0, 2'd0, 32'h0);
        in_port = 10'h001;
        repeat (3) step();
        in_port = 10'h000;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("glitch_data%0d", k), readdata, 32'h0);
        end
        bus(1'b1, 1'b0, 2'd3, 32'h0);
        step();
        chk("glitch_edgecap", readdata, 32'h0);
        chk("glitch_irq", 32'(irq), 32'h0);

        // 0x000 -> 0x3FF: stable after 6 edges from drive, readdata one later
        bus(1'b1, 1'b0, 2'd0, 32'h0);
        in_port = 10'h3FF;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("rise_data%0d", k), readdata, (k >= 7) ? 32'h3FF : 32'h0);
            chk($sformatf("rise_irq%0d", k), 32'(irq), (k >= 7) ? 32'h1 : 32'h0);
        end
        bus(1'b1, 1'b0, 2'd3, 32'h0);
        step();
        chk("rise_edgecap", readdata, 32'h3FF);
        // clear bit 0: irq drops immediately after the write edge
        bus(1'b1, 1'b1, 2'd3, 32'h1);
        step();
        chk("w1c0_irq", 32'(irq), 32'h0);
        chk("w1c0_rd_old", readdata, 32'h3FF);
        bus(1'b1, 1'b0, 2'd3, 32'h0);
        step();
        chk("w1c0_edgecap", readdata, 32'h3FE);
        bus(1'b1, 1'b1, 2'd3, 32'h3FF);
        step();
        bus(1'b1, 1'b0, 2'd3, 32'h0);
        step();
        chk("w1c_all", readdata, 32'h0);

        // bit 2 falls; clear it in the same cycle its edge event sets it
        in_port = 10'h3FB;
        repeat (6) step();
        bus(1'b1, 1'b1, 2'd3, 32'h4);
        step();
        chk("race_rd_old", readdata, 32'h0);
        bus(1'b1, 1'b0, 2'd3, 32'h0);
        step();
        chk("race_event_wins", readdata, 32'h4);
        chk("race_irq", 32'(irq), 32'h0);
        bus(1'b1, 1'b1, 2'd3, 32'h4);
        step();
        bus(1'b1, 1'b0, 2'd0, 32'h0);
        step();
        chk("data_3fb", readdata, 32'h3FB);
        bus(1'b1, 1'b0, 2'd3, 32'h0);
        step();
        chk("race_cleared", readdata, 32'h0);

        // reset in the middle of a debounce
        bus(1'b1, 1'b0, 2'd0, 32'h0);
        in_port = 10'h200;
        repeat (2) step();
        reset = 1'b1;
        #1;
        chk("midrst_readdata", readdata, 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        repeat (2) step();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("post_rst_data%0d", k), readdata, (k >= 7) ? 32'h200 : 32'h0);
        end
        bus(1'b1, 1'b0, 2'd1, 32'h0);
        step();
        chk("post_rst_mask", readdata, 32'h0);
        bus(1'b1, 1'b0, 2'd3, 32'h0);
        step();
        chk("post_rst_edgecap", readdata, 32'h200);
        chk("post_rst_irq", 32'(irq), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tag_nios_system_debounced_pio.md
TAG_NIOS_SYSTEM_DEBOUNCED_PIO -- requirements
Module: tag_nios_system_debounced_pio

Interface
REQ-001 Parameter WIDTH, default 10: number of input bits, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a change, legal range >=1.
REQ-003 Parameter EDGE_TYPE, default 2: 0 = rising, 1 = falling, 2 = any edge captured.
REQ-004 Port clk, input, 1: single clock, all logic rising-edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port chipselect, input, 1: Avalon-MM slave select.
REQ-007 Port address, input, 2: word register offset.
REQ-008 Port write, input, 1: write strobe, qualified by chipselect.
REQ-009 Port writedata, input, 32: write data.
REQ-010 Port in_port, input, WIDTH: asynchronous external inputs (switches/keys).
REQ-011 Port readdata, output, 32: registered read data.
REQ-012 Port irq, output, 1: level interrupt request.

Function
REQ-013 Each in_port bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 Each bit SHALL keep a stable value and a mismatch counter: the counter clears when sync2 == stable; on each cycle with sync2 != stable it increments; when a mismatch cycle occurs with counter == DEBOUNCE_CYCLES-1, stable <= sync2 and the counter clears.
REQ-015 A level change held on in_port SHALL update stable exactly DEBOUNCE_CYCLES+1 rising edges after the edge at which sync1 captures it.
REQ-016 A pulse shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL leave stable unchanged and the counter cleared.
REQ-017 The counter width SHALL be clog2(DEBOUNCE_CYCLES), minimum 1 bit, and SHALL never wrap.
REQ-018 The register map SHALL be: 0 data (stable, read-only); 1 irq_mask (R/W, WIDTH bits); 2 reserved (reads 0); 3 edge_capture (read, write-1-to-clear).
REQ-019 An edge event SHALL be a transition of stable matching EDGE_TYPE, and SHALL set the corresponding edge_capture bit on the following edge.
REQ-020 A write to offset 3 SHALL clear each edge_capture bit whose writedata bit is 1; a simultaneous edge event on that bit SHALL win (bit stays 1).
REQ-021 Writes to offsets 0 and 2 SHALL be ignored; writedata bits above WIDTH SHALL be ignored.
REQ-022 readdata SHALL update every cycle to the zero-extended contents of the register at address, giving 1-cycle read latency, independent of chipselect.
REQ-023 irq SHALL be combinational OR of (edge_capture & irq_mask), with no additional latency.

Reset
REQ-024 Reset SHALL force sync1, sync2, stable, all counters, irq_mask, edge_capture and readdata to 0; irq therefore SHALL be 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; after release, in_port held at 1 SHALL produce a rising-edge capture once debounced.

Structure
REQ-026 Register offsets (DATA, IRQ_MASK, RSVD, EDGE_CAP) and the EDGE_TYPE encodings SHALL be constants in shared package tag_nios_system_pio_pkg.
REQ-027 The per-bit synchronizer, counter and stable register SHALL form sub-module tag_nios_system_debounce_bit, instantiated WIDTH times via generate.

Verification (WIDTH=10, DEBOUNCE_CYCLES=4, EDGE_TYPE=2)
REQ-028 Reset, then read offset 0 with in_port=0 -> readdata=0x0, irq=0.
REQ-029 in_port 0x000->0x3FF, held; read offset 0 every cycle -> stable=0x3FF exactly 5 edges after sync1 capture, readdata one cycle later; edge_capture=0x3FF.
REQ-030 Glitch in_port[0]=1 for 3 cycles, then 0 -> data stays 0x000, edge_capture stays 0.
REQ-031 Write irq_mask=0x001, trigger bit-0 edge -> irq=1; write 0x001 to offset 3 -> edge_capture[0]=0, irq=0 next cycle.
REQ-032 Write-1-to-clear bit 2 in the same cycle that bit 2's edge event sets it -> edge_capture[2]=1 afterwards.
REQ-033 Assert reset 2 cycles into a debounce of in_port=0x200 -> all registers 0; after release, stable=0x200 after a full 5-edge debounce.
